// File: rtl/gdu.sv
// Generalized data unpacker: takes one N*M-bit packed word and emits it as N-bit lanes, lane 0 first.
// Optional macro GDU_LAST_EN adds the dout_last output marking the final lane of each word.
module gdu #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int LOG2M = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N*M-1:0]   din,
  input  logic [LOG2M-1:0] din_lanes,
  input  logic             valid_din,
  output logic             ready_din,
  output logic [N-1:0]     dout,
  output logic             valid_dout,
`ifdef GDU_LAST_EN
  output logic             dout_last,
`endif
  input  logic             ready_dout
);

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [LOG2M-1:0] LANE_ONE = 1;

  state_t                  state_q, state_d;
  logic [M-1:0][N-1:0]     hold_q, hold_d;
  logic [LOG2M-1:0]        lane_q, lane_d;
  logic [LOG2M-1:0]        last_q, last_d;
  logic [LOG2M-1:0]        lanes_clamped;
  logic                    at_last;
  logic                    in_xfer;
  logic                    out_xfer;

  // Lane-count encodings above M-1 only exist when M is not a power of two.
  generate
    if ((1 << LOG2M) > M) begin : g_clamp
      localparam logic [LOG2M-1:0] LAST_MAX = LOG2M'(M - 1);
      assign lanes_clamped = (din_lanes > LAST_MAX) ? LAST_MAX : din_lanes;
    end else begin : g_no_clamp
      assign lanes_clamped = din_lanes;
    end
  endgenerate

  assign at_last = (lane_q == last_q);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    lane_d     = lane_q;
    last_d     = last_q;
    ready_din  = 1'b0;
    valid_dout = 1'b0;

    case (state_q)
      EMPTY: ready_din = 1'b1;
      DRAIN: begin
        valid_dout = 1'b1;
        ready_din  = at_last & ready_dout;
      end
      default: ;
    endcase

    if (!reset_n) begin
      ready_din  = 1'b0;
      valid_dout = 1'b0;
    end

    in_xfer  = valid_din & ready_din;
    out_xfer = valid_dout & ready_dout;

    if ((state_q == DRAIN) && out_xfer) begin
      if (!at_last) begin
        lane_d = lane_q + LANE_ONE;
      end else begin
        lane_d  = '0;
        state_d = EMPTY;
      end
    end

    // A new word can only arrive when the held one is empty or leaving this cycle.
    if (in_xfer) begin
      hold_d  = din;
      last_d  = lanes_clamped;
      lane_d  = '0;
      state_d = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      lane_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
    end
  end

  assign dout = valid_dout ? hold_q[lane_q] : '0;

`ifdef GDU_LAST_EN
  assign dout_last = valid_dout & at_last;
`endif

endmodule

// File: tb/tb_gdu.sv
// Directed bench for gdu: reset, full/partial/clamped words, mid-word reset and a
// randomly backpressured incrementing byte stream.
module tb_gdu;

  logic        clk;
  logic        reset_n;
  logic [31:0] din;
  logic [1:0]  din_lanes;
  logic        valid_din;
  logic        ready_din;
  logic [7:0]  dout;
  logic        valid_dout;
  logic        ready_dout;
  logic        dout_last;

  logic [44:0] din5;
  logic [2:0]  lanes5;
  logic        valid5;
  logic        rdin5;
  logic [8:0]  dout5;
  logic        vdout5;
  logic        last5;

  int n_cmp = 0;
  int n_err = 0;

  gdu #(.N(8), .M(4), .LOG2M(2)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_lanes  (din_lanes),
    .valid_din  (valid_din),
    .ready_din  (ready_din),
    .dout       (dout),
    .valid_dout (valid_dout),
`ifdef GDU_LAST_EN
    .dout_last  (dout_last),
`endif
    .ready_dout (ready_dout)
  );

  gdu #(.N(9), .M(5), .LOG2M(3)) u_dut5 (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din5),
    .din_lanes  (lanes5),
    .valid_din  (valid5),
    .ready_din  (rdin5),
    .dout       (dout5),
    .valid_dout (vdout5),
`ifdef GDU_LAST_EN
    .dout_last  (last5),
`endif
    .ready_dout (1'b1)
  );

`ifndef GDU_LAST_EN
  assign dout_last = 1'b0;
  assign last5     = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d,
                            input logic r, input logic l);
    chk({tag, ".valid_dout"}, 64'(valid_dout), 64'(v));
    chk({tag, ".dout"},       64'(dout),       64'(d));
    chk({tag, ".ready_din"},  64'(ready_din),  64'(r));
`ifdef GDU_LAST_EN
    chk({tag, ".dout_last"},  64'(dout_last),  64'(l));
`else
    if (l === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input int k);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(4 * k);
    b1 = 8'(4 * k + 1);
    b2 = 8'(4 * k + 2);
    b3 = 8'(4 * k + 3);
    return {b3, b2, b1, b0};
  endfunction

  initial begin
    int got;
    int cyc;
    int err0;
    int k;
    logic [7:0] exp_b;
    logic [7:0] prev_d;
    logic prev_stall;

    reset_n    = 1'b0;
    valid_din  = 1'b1;
    din        = 32'hDEADBEEF;
    din_lanes  = 2'd3;
    ready_dout = 1'b1;
    valid5     = 1'b0;
    din5       = '0;
    lanes5     = '0;

    // reset held with valid_din asserted
    repeat (5) @(posedge clk);
    @(negedge clk);
    expect_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    reset_n   = 1'b1;
    valid_din = 1'b0;
    @(negedge clk);
    expect_out("post_reset", 1'b0, 8'h00, 1'b1, 1'b0);

    // full word followed back-to-back by a second full word, then a 2-lane word
    tick();
    din = 32'h44332211; din_lanes = 2'd3; valid_din = 1'b1;
    @(negedge clk);
    expect_out("w1_accept", 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    din = 32'h88776655;
    @(negedge clk); expect_out("w1_l0", 1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    @(negedge clk); expect_out("w1_l1", 1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    @(negedge clk); expect_out("w1_l2", 1'b1, 8'h33, 1'b0, 1'b0);
    tick();
    @(negedge clk); expect_out("w1_l3", 1'b1, 8'h44, 1'b1, 1'b1);
    tick();
    din = 32'hDDCCBBAA; din_lanes = 2'd1;
    @(negedge clk); expect_out("w2_l0", 1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    @(negedge clk); expect_out("w2_l1", 1'b1, 8'h66, 1'b0, 1'b0);
    tick();
    @(negedge clk); expect_out("w2_l2", 1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    @(negedge clk); expect_out("w2_l3", 1'b1, 8'h88, 1'b1, 1'b1);
    tick();
    valid_din = 1'b0;
    @(negedge clk); expect_out("w3_l0", 1'b1, 8'hAA, 1'b0, 1'b0);
    tick();
    @(negedge clk); expect_out("w3_l1", 1'b1, 8'hBB, 1'b1, 1'b1);
    tick();
    @(negedge clk); expect_out("w3_done", 1'b0, 8'h00, 1'b1, 1'b0);

    // single-lane word
    tick();
    din = 32'h000000EE; din_lanes = 2'd0; valid_din = 1'b1;
    @(negedge clk); expect_out("w4_accept", 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    valid_din = 1'b0;
    @(negedge clk); expect_out("w4_l0", 1'b1, 8'hEE, 1'b1, 1'b1);
    tick();
    @(negedge clk); expect_out("w4_done", 1'b0, 8'h00, 1'b1, 1'b0);

    // N=9, M=5: din_lanes=7 clamps to 5 lanes
    tick();
    valid5 = 1'b1; lanes5 = 3'd7;
    din5   = {9'h105, 9'h104, 9'h103, 9'h102, 9'h101};
    @(negedge clk);
    chk("m5_accept.ready_din", 64'(rdin5), 64'd1);
    tick();
    valid5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("m5_lane.valid_dout", 64'(vdout5), 64'd1);
      chk("m5_lane.dout",       64'(dout5),  64'(9'h101 + i));
      chk("m5_lane.ready_din",  64'(rdin5),  64'(i == 4));
`ifdef GDU_LAST_EN
      chk("m5_lane.dout_last",  64'(last5),  64'(i == 4));
`endif
      tick();
    end
    @(negedge clk);
    chk("m5_no_sixth.valid_dout", 64'(vdout5), 64'd0);

    // reset asserted after lane 1 leaves; the next word must start clean at lane 0
    tick();
    din = 32'h0D0C0B0A; din_lanes = 2'd3; valid_din = 1'b1;
    @(negedge clk); expect_out("mr_accept", 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    valid_din = 1'b0;
    @(negedge clk); expect_out("mr_l0", 1'b1, 8'h0A, 1'b0, 1'b0);
    tick();
    @(negedge clk); expect_out("mr_l1", 1'b1, 8'h0B, 1'b0, 1'b0);
    tick();
    reset_n = 1'b0;
    @(negedge clk); expect_out("mr_in_reset", 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    din = 32'h14131211; valid_din = 1'b1;
    @(negedge clk); expect_out("mr_after", 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    valid_din = 1'b0;
    @(negedge clk); expect_out("mr_new_l0", 1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    ready_dout = 1'b1;
    @(negedge clk); expect_out("mr_new_l1", 1'b1, 8'h12, 1'b0, 1'b0);
    tick(); tick();
    @(negedge clk); expect_out("mr_new_l3", 1'b1, 8'h14, 1'b1, 1'b1);
    tick();

    // random backpressure over 2000 incrementing-byte words
    got = 0; cyc = 0; k = 0; exp_b = 8'h00; prev_stall = 1'b0; prev_d = 8'h00;
    err0 = n_err;
    din = word_of(0); din_lanes = 2'd3; valid_din = 1'b1;
    ready_dout = 1'($urandom_range(0, 1));
    while (got < 8000 && cyc < 40000 && (n_err - err0) < 10) begin
      @(negedge clk);
      if (prev_stall) chk("stall_hold", 64'(dout), 64'(prev_d));
      if (valid_dout && ready_dout) begin
        chk("stream", 64'(dout), 64'(exp_b));
        exp_b = exp_b + 8'd1;
        got++;
      end
      if (valid_din && ready_din) k++;
      prev_stall = valid_dout & ~ready_dout;
      prev_d     = dout;
      tick();
      valid_din  = (k < 2000);
      din        = word_of(k);
      ready_dout = 1'($urandom_range(0, 1));
      cyc++;
    end
    chk("stream_count", 64'(got), 64'd8000);
    chk("stream_words", 64'(k), 64'd2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
